// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter.
// Latches a winner's byte, pulses trmt, reports done on frame end.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   req, req_data  per-requester level request and packed bytes
//   ack            1-cycle pulse when a requester's byte is latched
//   done           1-cycle pulse when that requester's frame has left
//   trmt, tx_data  launch pulse and held byte to the transmitter
//   tx_done        transmitter frame-complete level
//   busy           high while not idle
//   grant_id       current or last-served requester
//
// Build option: define UART_ARB_PRIO0_EN to give requester 0
// strict priority over the round-robin group.
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        done,
    output logic                      trmt,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [IW-1:0]             grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]      ptr, ptr_n;
    logic [IW-1:0]      win, idx, grant_n;
    logic [IW:0]        sum;
    logic               win_vld;
    logic [DATA_W-1:0]  slot [NUM_REQ];
    logic [DATA_W-1:0]  tx_data_n;
    logic [NUM_REQ-1:0] ack_n, done_n;
    logic               trmt_n;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First set request searching upward from ptr with wrap.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ))
                sum = sum - (IW+1)'(NUM_REQ);
            idx = sum[IW-1:0];
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
`ifdef UART_ARB_PRIO0_EN
        if (req[0]) begin
            win_vld = 1'b1;
            win     = '0;
        end
`endif
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        grant_n   = grant_id;
        tx_data_n = tx_data;
        trmt_n    = 1'b0;
        ack_n     = '0;
        done_n    = '0;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    state_n    = LAUNCH;
                    grant_n    = win;
                    tx_data_n  = slot[win];
                    trmt_n     = 1'b1;
                    ack_n[win] = 1'b1;
                end
            end
            // tx_done may still be high from the previous
            // frame; wait for the transmitter to clear it.
            LAUNCH: begin
                if (!tx_done)
                    state_n = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    state_n          = IDLE;
                    done_n[grant_id] = 1'b1;
`ifdef UART_ARB_PRIO0_EN
                    if (grant_id != '0)
                        ptr_n = (grant_id == IW'(NUM_REQ-1)) ?
                                '0 : grant_id + IW'(1);
`else
                    ptr_n = (grant_id == IW'(NUM_REQ-1)) ?
                            '0 : grant_id + IW'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            trmt     <= 1'b0;
            ack      <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_id <= grant_n;
            tx_data  <= tx_data_n;
            trmt     <= trmt_n;
            ack      <= ack_n;
            done     <= done_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb.
// Arbitration reference model plus a simple transmitter model.
module tb_uart_tx_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req;
    logic [N*W-1:0] req_data;
    logic [N-1:0] ack, done;
    logic         trmt;
    logic [W-1:0] tx_data;
    logic         tx_done;
    logic         busy;
    logic [1:0]   grant_id;

    uart_tx_arb #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .done(done), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        bit           is_done;
        int           id;
        logic [W-1:0] data;
    } ev_t;

    ev_t q[$];
    int  total = 0, bad = 0, cyc = 0;
    bit  m_idle = 1'b1, seen0 = 1'b0;
    int  m_ptr = 0, m_gid = 0;
    int  mode = 0;
    logic [W-1:0] dat [N];
    int  frame_len = 8, clr_fix = -1;
    bit  frame_rand = 1'b0;
    int  n_ack = 0, n_ack2 = 0;
    int  gl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired cyc %0d", nm, cyc);
    endtask

    task automatic pack();
        req_data = '0;
        for (int k = 0; k < N; k++)
            req_data = req_data | ((N*W)'(dat[k]) << (k*W));
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] t;
`ifdef UART_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            t = r >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Reference model: decides at each edge what the DUT must emit.
    initial begin
        int  w;
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_idle = 1'b1; seen0 = 1'b0;
                m_ptr = 0; m_gid = 0;
            end else if (m_idle) begin
                if (req != '0) begin
                    w = pick(req, m_ptr);
                    e.cyc = cyc; e.is_done = 1'b0; e.id = w;
                    e.data = W'(req_data >> (w*W));
                    q.push_back(e);
                    m_idle = 1'b0; seen0 = 1'b0; m_gid = w;
                end
            end else if (seen0 && tx_done) begin
                e.cyc = cyc; e.is_done = 1'b1; e.id = m_gid;
                e.data = '0;
                q.push_back(e);
                m_idle = 1'b1;
`ifdef UART_ARB_PRIO0_EN
                if (m_gid != 0) m_ptr = (m_gid + 1) % N;
`else
                m_ptr = (m_gid + 1) % N;
`endif
            end else if (!tx_done) begin
                seen0 = 1'b1;
            end
        end
    end

    // Monitor: pops expectations and compares DUT outputs.
    initial begin
        logic [W-1:0] prev_tx, et;
        logic [N-1:0] ea, ed;
        ev_t e;
        prev_tx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                prev_tx = '0;
                chk("rst_outs",
                    {ack, done, trmt, busy, tx_data, grant_id}, 0);
            end else begin
                ea = '0; ed = '0; et = prev_tx;
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    void'(q.pop_front());
                    fail_now("missed_event");
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    if (e.is_done) ed = N'(1) << e.id;
                    else begin
                        ea = N'(1) << e.id;
                        et = e.data;
                    end
                end
                chk("ack", ack, ea);
                chk("trmt", trmt, |ea);
                chk("done", done, ed);
                chk("tx_data", tx_data, et);
                chk("busy", busy, !m_idle);
                chk("grant_id", grant_id, m_gid);
                if (ack != '0) begin
                    n_ack++;
                    gl.push_back(int'(grant_id));
                    if (ack[2]) n_ack2++;
                end
                prev_tx = tx_data;
            end
        end
    end

    // Transmitter model; clr_delay > 0 leaves a stale tx_done.
    initial begin
        int tph, tclr, tcnt;
        tph = 0; tclr = 0; tcnt = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_done = 1'b0; tph = 0;
            end else begin
                if (trmt) begin
                    tph = 1;
                    tclr = (clr_fix >= 0) ? clr_fix :
                           int'($urandom_range(0, 3));
                    if (frame_rand)
                        frame_len = int'($urandom_range(2, 30));
                end
                if (tph == 1) begin
                    if (tclr == 0) begin
                        tx_done = 1'b0; tcnt = frame_len; tph = 2;
                    end else tclr--;
                end else if (tph == 2) begin
                    if (tcnt == 0) begin
                        tx_done = 1'b1; tph = 0;
                    end else tcnt--;
                end
            end
        end
    end

    // Requester driver.
    initial begin
        logic [1:0]   i;
        logic [N-1:0] m;
        req = '0;
        for (int k = 0; k < N; k++) dat[k] = '0;
        pack();
        forever begin
            @(negedge clk);
            case (mode)
                0: req = '0;
                1: req = '1;
                2: for (int k = 0; k < N; k++) begin
                    i = 2'(k);
                    m = N'(1) << k;
                    if ((req & ack & m) != '0) begin
                        if ($urandom_range(0, 1) == 1)
                            dat[i] = W'($urandom);
                        else req = req & ~m;
                    end else if ((req & m) != '0) begin
                        if ($urandom_range(0, 99) < 3)
                            req = req & ~m;
                    end else if ($urandom_range(0, 99) < 15) begin
                        dat[i] = W'($urandom);
                        req = req | m;
                    end
                end
                default: req = req & ~ack;
            endcase
            pack();
        end
    end

    task automatic wait_acks(input int tgt, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #1;
            if (n_ack >= tgt) return;
        end
        fail_now("ack_timeout");
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #1;
            if (!busy && req == '0 && q.size() == 0) return;
        end
        fail_now("idle_timeout");
    endtask

    initial begin
        int exp_ord [5];
`ifdef UART_ARB_PRIO0_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        dat[0] = 8'h10; dat[1] = 8'h21;
        dat[2] = 8'h32; dat[3] = 8'h43;
        mode = 1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        wait_acks(5, 400);
        for (int k = 0; k < 5; k++)
            if (k < gl.size()) chk("order", gl[k], exp_ord[k]);
            else fail_now("order_len");
        mode = 0;
        wait_idle(200);

        mode = 3;
        @(negedge clk);
        #1;
        dat[2] = 8'hA5; req = 4'b0100; pack();
        wait_acks(n_ack + 1, 50);
        chk("a5_ack", ack, 4'b0100);
        chk("a5_trmt", trmt, 1);
        chk("a5_data", tx_data, 8'hA5);
        wait_idle(200);

        req = 4'b1001; pack();
        wait_acks(n_ack + 1, 50);
`ifdef UART_ARB_PRIO0_EN
        chk("ptr_next", gl[$], 0);
`else
        chk("ptr_next", gl[$], 3);
`endif
        wait_idle(200);

        clr_fix = 6;
        chk("stale_pre", tx_done, 1);
        req = 4'b0001; pack();
        wait_acks(n_ack + 1, 50);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("stale_hold", {busy, done}, 5'b10000);
        end
        wait_idle(200);
        clr_fix = -1;

        frame_len = 40;
        req = 4'b0001; pack();
        wait_acks(n_ack + 1, 50);
        n_ack2 = 0;
        repeat (3) @(negedge clk);
        #1;
        req = req | 4'b0100; pack();
        @(negedge clk);
        #1;
        req = (req & 4'b1011) | 4'b1000; pack();
        wait_idle(300);
        chk("wd_ack2", n_ack2, 0);
        chk("wd_next", gl[$], 3);

        frame_rand = 1'b1;
        mode = 2;
        repeat (3000) @(negedge clk);
        mode = 0;
        wait_idle(400);
        frame_rand = 1'b0;

        mode = 3;
        frame_len = 6000;
        @(negedge clk);
        #1;
        req = 4'b0100; pack();
        wait_acks(n_ack + 1, 50);
        repeat (5000) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst_now", {ack, done, trmt, busy, tx_data}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        frame_len = 8;
        @(negedge clk);
        #1;
        req = 4'b1000; pack();
        wait_acks(n_ack + 1, 50);
        chk("rst_grant", gl[$], 3);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte requesters.
- Picks a winner, latches its byte, and launches the transmitter with a one-cycle trmt pulse.
- Tracks the transmitter's tx_done level to detect frame completion, then reports completion back to the winning requester.
- Sits between the command/telemetry sources and the UART transmitter in the serial link.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the transmitter's tx_data width.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  per-requester transmit request; level, held until ack.
- req_data  input  NUM_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W]; stable while req[i] is high.
- ack  output  NUM_REQ  one-cycle pulse: the byte is latched, and the requester may change data or drop req.
- done  output  NUM_REQ  one-cycle pulse: that requester's frame has fully left the transmitter.
- trmt  output  1  to the transmitter; one-cycle launch pulse.
- tx_data  output  DATA_W  to the transmitter; latched byte, held stable from launch until done.
- tx_done  input  1  from the transmitter; cleared on the cycle after trmt, set at the end of the stop bit.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last-served requester.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - trmt, ack, done, busy = 0; tx_data = 0; grant_id = 0; round-robin pointer ptr = 0.
  - No done pulse is issued for a frame aborted by reset.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - req sampled every cycle; tx_done ignored.
  - If req != 0, choose the winner: first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
  - Next edge: grant_id <= winner; tx_data <= req_data slice of winner; trmt <= 1; ack[winner] <= 1; state -> LAUNCH.
- LAUNCH:
  - trmt and ack return to 0 (each is exactly one cycle wide).
  - Stay until tx_done == 0, then go to WAIT. This guards against a stale tx_done from the previous frame.
- WAIT:
  - Stay until tx_done == 1.
  - Then, next edge: done[grant_id] <= 1 for one cycle; ptr <= (grant_id+1) mod NUM_REQ; state -> IDLE.
- Latency:
  - req high in IDLE to trmt high: 1 cycle.
  - Back-to-back frames: one IDLE cycle minimum between done and the next trmt.
- Request handling:
  - A req dropped before ack is a withdrawal; no ack is issued and no penalty applies.
  - A req still high on the IDLE cycle after done is treated as a new byte.
  - Requests arriving during LAUNCH/WAIT wait; they are never lost or reordered.
- Fairness: a requester that held req continuously is served within NUM_REQ grants.
- Simultaneous events: done for frame k and the ack for frame k+1 never share a cycle.
- tx_data never changes outside the IDLE->LAUNCH edge.

Optional Feature:
- Macro: UART_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. In IDLE, if req[0] is set it wins regardless of ptr. A grant to 0 does not update ptr. Other requesters keep round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Single request, with a tx_done model: req=4'b0100, data 0xA5:
  - trmt pulses 1 cycle after req; ack=4'b0100 on the same cycle; tx_data=0xA5.
  - After tx_done rises, done=4'b0100 for 1 cycle; busy drops; ptr=3.
- All four requesting continuously from reset, bytes 0x10/0x21/0x32/0x43:
  - Grant order 0,1,2,3,0; tx_data sequence 0x10,0x21,0x32,0x43.
  - Exactly one ack and one done per frame.
- Stale tx_done: tx_done held high in IDLE from the prior frame, then req=4'b0001:
  - Arbiter stays in LAUNCH until the model clears tx_done.
  - No premature done.
- Withdrawal: req[2] pulsed high for 1 cycle while busy:
  - No ack[2] ever.
  - The next grant goes to the next pending requester.
- Reset mid-WAIT: assert rst 5000 cycles into a frame:
  - All outputs 0 immediately; no done pulse.
  - After release, req=4'b1000 is granted with ptr starting from 0.
- UART_ARB_PRIO0_EN defined, req=4'b1111 held:
  - Grants 0,0,0...; ack[1..3] never asserted.
  - Drop req[0] -> grants 1,2,3 round-robin.
